// File: rtl/bus_arbiter_mux.sv
// Registered bus multiplexer: direct select or round-robin arbitration over NSRC sources.
// The output word holds when the bus goes idle; out-of-range direct selects raise a sticky flag.
module bus_arbiter_mux #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  localparam int SELW = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  input  logic                  sel_valid,
  input  logic [NSRC-1:0]       req,
  input  logic                  lock,
  input  logic                  err_clr,
  output logic [WIDTH-1:0]      bus_out,
  output logic                  bus_valid,
  output logic [NSRC-1:0]       grant,
  output logic [SELW-1:0]       grant_idx,
  output logic                  sel_err
);

  logic [WIDTH-1:0] w_src [NSRC];
  logic [SELW:0]    w_rr;
  logic             w_lock_hold;
  logic             w_sel_ok;
  logic             w_load;
  logic             w_err_set;
  logic [SELW-1:0]  w_pick;

  logic [WIDTH-1:0] r_bus_p1;
  logic             r_vld_p1;
  logic [NSRC-1:0]  r_grant_p1;
  logic [SELW-1:0]  r_grant_idx_p1;
  logic             r_sel_err_p1;
  logic [SELW-1:0]  r_ptr;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    assign w_src[gi] = src_data[gi*WIDTH +: WIDTH];
  end

  function automatic logic [NSRC-1:0] onehot(input logic [SELW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Scan from farthest to nearest so the requester closest after ptr is the one that sticks;
  // ptr itself is distance NSRC, i.e. checked last.
  function automatic logic [SELW:0] rr_search(input logic [SELW-1:0] ptr,
                                               input logic [NSRC-1:0] rq);
    int c;
    rr_search = '0;
    for (int k = NSRC; k >= 1; k--) begin
      c = (int'(ptr) + k) % NSRC;
      if (rq[SELW'(c)]) rr_search = {1'b1, SELW'(c)};
    end
  endfunction

  assign w_rr        = rr_search(r_ptr, req);
  assign w_lock_hold = lock && r_grant_p1[r_grant_idx_p1] && req[r_grant_idx_p1];
  assign w_sel_ok    = ({1'b0, sel} < (SELW+1)'(NSRC));

  always_comb begin
    w_load    = 1'b0;
    w_err_set = 1'b0;
    w_pick    = r_grant_idx_p1;
    if (mode) begin
      if (w_lock_hold) begin
        w_load = 1'b1;
      end else if (w_rr[SELW]) begin
        w_load = 1'b1;
        w_pick = w_rr[SELW-1:0];
      end
    end else if (sel_valid) begin
      if (w_sel_ok) begin
        w_load = 1'b1;
        w_pick = sel;
      end else begin
        w_err_set = 1'b1;
      end
    end
  end

  // Stage p1: registered bus word, grant and status
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_bus_p1       <= '0;
      r_vld_p1       <= 1'b0;
      r_grant_p1     <= '0;
      r_grant_idx_p1 <= '0;
      r_sel_err_p1   <= 1'b0;
      r_ptr          <= SELW'(NSRC-1);
    end else begin
      r_vld_p1   <= w_load;
      r_grant_p1 <= w_load ? onehot(w_pick) : '0;
      if (w_load) begin
        r_bus_p1       <= w_src[w_pick];
        r_grant_idx_p1 <= w_pick;
      end
      if (mode && w_load) r_ptr <= w_pick;
      if (w_err_set)    r_sel_err_p1 <= 1'b1;
      else if (err_clr) r_sel_err_p1 <= 1'b0;
    end
  end

  assign bus_out   = r_bus_p1;
  assign bus_valid = r_vld_p1;
  assign grant     = r_grant_p1;
  assign grant_idx = r_grant_idx_p1;
  assign sel_err   = r_sel_err_p1;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Scoreboard bench for bus_arbiter_mux: directed stimulus queues expected outputs,
// a monitor pops and compares after each rising edge or on an explicit asynchronous sample.
module tb_bus_arbiter_mux;
  localparam int WIDTH = 32;
  localparam int NSRC  = 24;
  localparam int SELW  = 5;

  logic                  clk = 1'b0;
  logic                  clear = 1'b1;
  logic [NSRC*WIDTH-1:0] src_data;
  logic                  mode = 1'b0;
  logic [SELW-1:0]       sel = '0;
  logic                  sel_valid = 1'b0;
  logic [NSRC-1:0]       req = '0;
  logic                  lock = 1'b0;
  logic                  err_clr = 1'b0;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [NSRC-1:0]       grant;
  logic [SELW-1:0]       grant_idx;
  logic                  sel_err;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] bus;
    logic             vld;
    logic [NSRC-1:0]  gnt;
    logic [SELW-1:0]  idx;
    logic             err;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event sample_ev;

  localparam logic [NSRC-1:0] ONE = 24'd1;

  bus_arbiter_mux #(.WIDTH(WIDTH), .NSRC(NSRC)) dut (
    .clk(clk), .clear(clear), .src_data(src_data), .mode(mode), .sel(sel),
    .sel_valid(sel_valid), .req(req), .lock(lock), .err_clr(err_clr),
    .bus_out(bus_out), .bus_valid(bus_valid), .grant(grant),
    .grant_idx(grant_idx), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic set_src(input int i, input logic [WIDTH-1:0] v);
    src_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic expect_out(input string nm, input logic [WIDTH-1:0] b, input logic v,
                            input logic [NSRC-1:0] g, input logic [SELW-1:0] idx,
                            input logic e);
    exp_t x;
    x.name = nm; x.bus = b; x.vld = v; x.gnt = g; x.idx = idx; x.err = e;
    q.push_back(x);
  endtask

  task automatic drive(input logic m, input logic [SELW-1:0] s, input logic sv,
                       input logic [NSRC-1:0] r, input logic lk, input logic ec);
    @(negedge clk);
    mode = m; sel = s; sel_valid = sv; req = r; lock = lk; err_clr = ec;
  endtask

  // Monitor: one comparison per queued expectation
  initial begin
    exp_t x;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        n_cmp++;
        if (bus_out !== x.bus || bus_valid !== x.vld || grant !== x.gnt ||
            grant_idx !== x.idx || sel_err !== x.err) begin
          n_bad++;
          $display("FAIL %s: got bus=%h vld=%b gnt=%h idx=%0d err=%b, want bus=%h vld=%b gnt=%h idx=%0d err=%b",
                   x.name, bus_out, bus_valid, grant, grant_idx, sel_err,
                   x.bus, x.vld, x.gnt, x.idx, x.err);
        end
      end
    end
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    for (int i = 0; i < NSRC; i++) set_src(i, 32'hA000_0000 + 32'(i));
    set_src(5, 32'hDEAD_BEEF);
    #1 clear = 1'b0;
    repeat (2) @(negedge clk);
    expect_out("reset", '0, 1'b0, '0, '0, 1'b0);
    ->sample_ev;
    @(negedge clk);
    clear = 1'b1;

    // Direct mode, idle hold, out-of-range handling
    drive(1'b0, 5'd5, 1'b1, '0, 1'b0, 1'b0);
    expect_out("direct_sel5", 32'hDEAD_BEEF, 1'b1, ONE << 5, 5'd5, 1'b0);
    drive(1'b0, 5'd5, 1'b0, '0, 1'b0, 1'b0);
    set_src(5, 32'h0000_0001);
    expect_out("idle_hold", 32'hDEAD_BEEF, 1'b0, '0, 5'd5, 1'b0);
    drive(1'b0, 5'd7, 1'b1, '1, 1'b1, 1'b0);
    set_src(5, 32'hA000_0005);
    expect_out("direct_sel7", 32'hA000_0007, 1'b1, ONE << 7, 5'd7, 1'b0);
    drive(1'b0, 5'd30, 1'b1, '0, 1'b0, 1'b0);
    expect_out("oor_set", 32'hA000_0007, 1'b0, '0, 5'd7, 1'b1);
    drive(1'b0, 5'd31, 1'b1, '0, 1'b0, 1'b1);
    expect_out("oor_set_wins", 32'hA000_0007, 1'b0, '0, 5'd7, 1'b1);
    drive(1'b0, 5'd31, 1'b0, '0, 1'b0, 1'b1);
    expect_out("err_clr", 32'hA000_0007, 1'b0, '0, 5'd7, 1'b0);
    drive(1'b0, 5'd23, 1'b1, '0, 1'b0, 1'b0);
    expect_out("direct_sel23", 32'hA000_0017, 1'b1, ONE << 23, 5'd23, 1'b0);
    drive(1'b0, 5'd0, 1'b1, '0, 1'b0, 1'b0);
    expect_out("direct_sel0", 32'hA000_0000, 1'b1, ONE, 5'd0, 1'b0);

    // Round robin over {0,3,23}; pointer still at its reset value
    drive(1'b1, 5'd30, 1'b1, (ONE << 0) | (ONE << 3) | (ONE << 23), 1'b0, 1'b0);
    expect_out("rr_0a", 32'hA000_0000, 1'b1, ONE, 5'd0, 1'b0);
    drive(1'b1, 5'd0, 1'b0, (ONE << 0) | (ONE << 3) | (ONE << 23), 1'b0, 1'b0);
    expect_out("rr_3a", 32'hA000_0003, 1'b1, ONE << 3, 5'd3, 1'b0);
    drive(1'b1, 5'd0, 1'b0, (ONE << 0) | (ONE << 3) | (ONE << 23), 1'b0, 1'b0);
    expect_out("rr_23a", 32'hA000_0017, 1'b1, ONE << 23, 5'd23, 1'b0);
    drive(1'b1, 5'd0, 1'b0, (ONE << 0) | (ONE << 3) | (ONE << 23), 1'b0, 1'b0);
    expect_out("rr_0b", 32'hA000_0000, 1'b1, ONE, 5'd0, 1'b0);
    drive(1'b1, 5'd0, 1'b0, (ONE << 0) | (ONE << 3) | (ONE << 23), 1'b0, 1'b0);
    expect_out("rr_3b", 32'hA000_0003, 1'b1, ONE << 3, 5'd3, 1'b0);
    drive(1'b1, 5'd0, 1'b0, (ONE << 0) | (ONE << 3) | (ONE << 23), 1'b0, 1'b0);
    expect_out("rr_23b", 32'hA000_0017, 1'b1, ONE << 23, 5'd23, 1'b0);
    drive(1'b1, 5'd0, 1'b0, '0, 1'b0, 1'b0);
    expect_out("rr_idle", 32'hA000_0017, 1'b0, '0, 5'd23, 1'b0);

    // Lock keeps the holder until it drops its request
    drive(1'b1, 5'd0, 1'b0, (ONE << 2) | (ONE << 7), 1'b0, 1'b0);
    expect_out("lock_first", 32'hA000_0002, 1'b1, ONE << 2, 5'd2, 1'b0);
    drive(1'b1, 5'd0, 1'b0, (ONE << 2) | (ONE << 7), 1'b1, 1'b0);
    expect_out("lock_hold1", 32'hA000_0002, 1'b1, ONE << 2, 5'd2, 1'b0);
    drive(1'b1, 5'd0, 1'b0, (ONE << 2) | (ONE << 7), 1'b1, 1'b0);
    expect_out("lock_hold2", 32'hA000_0002, 1'b1, ONE << 2, 5'd2, 1'b0);
    drive(1'b1, 5'd0, 1'b0, ONE << 7, 1'b1, 1'b0);
    expect_out("lock_drop", 32'hA000_0007, 1'b1, ONE << 7, 5'd7, 1'b0);
    drive(1'b1, 5'd0, 1'b0, (ONE << 2) | (ONE << 7), 1'b0, 1'b0);
    expect_out("unlock_wrap", 32'hA000_0002, 1'b1, ONE << 2, 5'd2, 1'b0);
    drive(1'b1, 5'd0, 1'b0, '1, 1'b0, 1'b0);
    expect_out("rr_all_3", 32'hA000_0003, 1'b1, ONE << 3, 5'd3, 1'b0);

    // Asynchronous reset pulse between edges
    @(negedge clk);
    #1 clear = 1'b0;
    #1;
    expect_out("async_reset", '0, 1'b0, '0, '0, 1'b0);
    ->sample_ev;
    #2 clear = 1'b1;
    mode = 1'b1; req = '1; lock = 1'b0;
    expect_out("post_reset_0", 32'hA000_0000, 1'b1, ONE, 5'd0, 1'b0);

    // Fairness: every source once per NSRC cycles
    for (int k = 1; k <= NSRC; k++) begin
      drive(1'b1, 5'd0, 1'b0, '1, 1'b0, 1'b0);
      expect_out("fair", 32'hA000_0000 + 32'(k % NSRC), 1'b1,
                 ONE << (k % NSRC), SELW'(k % NSRC), 1'b0);
    end

    // Pointer survives a detour through direct mode
    drive(1'b0, 5'd9, 1'b0, '1, 1'b0, 1'b0);
    expect_out("mode_idle", 32'hA000_0000, 1'b0, '0, 5'd0, 1'b0);
    drive(1'b1, 5'd0, 1'b0, (ONE << 0) | (ONE << 3), 1'b0, 1'b0);
    expect_out("ptr_kept", 32'hA000_0003, 1'b1, ONE << 3, 5'd3, 1'b0);
    drive(1'b0, 5'd0, 1'b0, '0, 1'b0, 1'b0);
    expect_out("final_idle", 32'hA000_0003, 1'b0, '0, 5'd3, 1'b0);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_mux.md
# bus_arbiter_mux

Parametrised, registered successor to the datapath bus multiplexer. It merges NSRC source words of WIDTH bits onto the shared processor bus, in one of two runtime modes: direct select from the control unit, or round-robin arbitration among requesting sources with optional grant lock. The output stage is registered, holds the last driven word when the bus is idle, and flags out-of-range selects. It sits between the register file, special registers (HI, LO, Z, PC, MDR, In-Port, C) and every bus consumer.

## Interface
- WIDTH, 32: bit width of each source and of the bus.
- NSRC, 24: number of sources, 2..64.
- SELW, $clog2(NSRC): select width; derived localparam, not overridable.
- clk  in  1  rising-edge clock.
- clear  in  1  reset; asynchronous and active-low.
- src_data  in  NSRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
- mode  in  1  0 = direct select, 1 = round-robin arbitration.
- sel  in  SELW  source index in direct mode.
- sel_valid  in  1  sel is meaningful this cycle (direct mode only).
- req  in  NSRC  per-source bus request (arbitration mode only).
- lock  in  1  keep the current grant while its holder still requests (arbitration mode only).
- err_clr  in  1  clears sel_err.
- bus_out  out  WIDTH  registered bus word.
- bus_valid  out  1  bus_out was loaded at the last edge.
- grant  out  NSRC  one-hot owner of bus_out; all zero when idle.
- grant_idx  out  SELW  binary index of the last granted source.
- sel_err  out  1  sticky out-of-range select flag.

## Operation
- Asynchronous reset (clear=0): bus_out=0, bus_valid=0, grant=0, grant_idx=0, sel_err=0, round-robin pointer ptr=NSRC-1, so the first search starts at index 0.
- Direct mode (mode=0):
  - If sel_valid=1 and sel<NSRC: bus_out<=src[sel], bus_valid<=1, grant<=onehot(sel), grant_idx<=sel.
  - If sel_valid=1 and sel>=NSRC: bus_valid<=0, grant<=0, sel_err<=1. bus_out and grant_idx hold.
  - If sel_valid=0: bus_valid<=0, grant<=0. bus_out and grant_idx hold.
  - req and lock are ignored. ptr is unchanged.
- Arbitration mode (mode=1):
  - If lock=1, grant[grant_idx]=1 and req[grant_idx]=1, keep the same winner.
  - Otherwise the winner is the first set req bit scanning ptr+1, ptr+2, … with wrap from NSRC-1 to 0. ptr itself is checked last.
  - On a win: bus_out<=src[winner], bus_valid<=1, grant<=onehot(winner), grant_idx<=winner, ptr<=winner.
  - If req=0: bus_valid<=0, grant<=0. bus_out, grant_idx and ptr hold.
  - sel, sel_valid and sel_err setting are ignored.
- Idle hold: bus_out never returns to 0 except on reset. Consumers qualify bus_out with bus_valid.
- sel_err clears on err_clr=1. If a set and a clear occur in the same cycle, set wins.
- A mode change takes effect at the next edge. ptr is preserved across mode changes.
- src_data is sampled only for the chosen source at the edge.

## Timing
- Latency is one cycle: inputs sampled at edge k appear on the outputs after edge k. There is no combinational path from inputs to outputs.
- Fairness: with all NSRC bits of req continuously high and lock=0, each source is granted exactly once per NSRC cycles.
- Lock bounds fairness only through the requester: a winner that drops req loses the grant at the next edge, even if lock=1.
- Reset asserted mid-transfer clears outputs immediately, without waiting for a clock edge. The first edge after deassertion behaves as a normal sample.
- Sources that change in the same cycle as the select are sampled with their pre-edge value.

## Test plan
- Reset/direct: assert clear=0 with src[5]=0xDEADBEEF; outputs are 0. Release, mode=0, sel=5, sel_valid=1 -> one edge later bus_out=0xDEADBEEF, bus_valid=1, grant=1<<5, grant_idx=5.
- Idle hold: after the above, drop sel_valid and change src[5] to 0x1 -> bus_out stays 0xDEADBEEF, bus_valid=0, grant=0.
- Out-of-range: NSRC=24, sel=30, sel_valid=1 -> sel_err=1, bus_valid=0, bus_out held. err_clr=1 together with sel=31 -> sel_err stays 1. err_clr=1 with sel_valid=0 -> sel_err=0.
- Round-robin: mode=1, req=bits {0,3,23} held for 6 cycles from reset -> grant_idx sequence 0,3,23,0,3,23.
- Lock: mode=1, req={2,7}, lock=1 after 2 is granted -> grant_idx=2 repeats. Drop req[2] -> next edge grant_idx=7.
- Async reset mid-operation: pulse clear low between edges during arbitration -> bus_valid, grant and bus_out are 0 before the next edge. Afterward, with all bits of req set, the first grant is index 0.
